// File: rtl/cdc_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdc_fifo_wr_arbiter
// Description : Round-robin scheduler for the cdcFifo write port. It uses a
//               zero-latency data mux and a registered grant FSM.
//               Optional macro ARB_PKT_LOCK_EN holds a grant until tlast.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 128,
    parameter int MAX_BURST = 16
) (
    input  logic                     wr_clk,
    input  logic                     wr_rst_n,
    input  logic [N_REQ*WIDTH-1:0]   req_tdata,
    input  logic [N_REQ-1:0]         req_tvalid,
    input  logic [N_REQ-1:0]         req_tlast,
    output logic [N_REQ-1:0]         req_tready,
    output logic [WIDTH-1:0]         wr_tdata,
    output logic                     wr_tvalid,
    input  logic                     wr_tready,
    output logic [$clog2(N_REQ)-1:0] grant_o,
    output logic                     grant_vld_o
);

    localparam int GW = $clog2(N_REQ);
    localparam int PW = GW + 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] C_LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t        state_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] rr_ptr_q;
    logic [CW-1:0] beat_cnt_q;

    logic          w_any;
    logic [GW-1:0] w_sel;
    logic [PW-1:0] w_idx;
    logic          w_beat;
    logic          w_release;
    logic [GW-1:0] w_next_ptr;
    logic [CW-1:0] w_cnt_inc;

    assign grant_o     = grant_q;
    assign grant_vld_o = (state_q == S_GRANT);

    assign wr_tdata  = req_tdata[int'(grant_q)*WIDTH +: WIDTH];
    assign wr_tvalid = grant_vld_o & req_tvalid[grant_q];
    assign w_beat    = wr_tvalid & wr_tready;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign req_tready[gi] = grant_vld_o & (grant_q == GW'(gi)) & wr_tready;
    end

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_any = |req_tvalid;
        w_sel = '0;
        w_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, rr_ptr_q} + PW'(k);
            if (w_idx >= PW'(N_REQ)) begin
                w_idx = w_idx - PW'(N_REQ);
            end
            if (req_tvalid[w_idx[GW-1:0]]) begin
                w_sel = w_idx[GW-1:0];
            end
        end
    end

    assign w_next_ptr = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
    assign w_cnt_inc  = (beat_cnt_q == C_LAST_BEAT) ? beat_cnt_q : beat_cnt_q + 1'b1;

`ifdef ARB_PKT_LOCK_EN
    assign w_release = w_beat & req_tlast[grant_q];
`else
    logic w_unused_tlast;
    assign w_unused_tlast = |req_tlast;
    // A dropped valid cannot coincide with a beat, so it releases on its own.
    assign w_release = (w_beat & (beat_cnt_q == C_LAST_BEAT)) | ~req_tvalid[grant_q];
`endif

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_any) begin
                        grant_q    <= w_sel;
                        beat_cnt_q <= '0;
                        state_q    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        rr_ptr_q   <= w_next_ptr;
                        beat_cnt_q <= '0;
                        state_q    <= S_IDLE;
                    end else if (w_beat) begin
                        beat_cnt_q <= w_cnt_inc;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
